addr_fetch_unit: RTL

ADDR_FETCH_UNIT -- requirements
Module: addr_fetch_unit

---
 rtl/ds_pkg.sv | 34 +++
 rtl/addr_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ds_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ds_pkg : shared FSM encoding and read-latency limits for the fetch unit |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package ds_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] lat_cnt_t;

  localparam state_t c_st_idle  = 3'd0;
  localparam state_t c_st_clr   = 3'd1;
  localparam state_t c_st_issue = 3'd2;
  localparam state_t c_st_wait  = 3'd3;
  localparam state_t c_st_hold  = 3'd4;
  localparam state_t c_st_done  = 3'd5;

  localparam int unsigned c_mem_lat_min = 1;
  localparam int unsigned c_mem_lat_max = 3;

  // Out-of-range latencies are pinned to the nearest legal value so the
  // 2-bit latency counter can never miss its terminal count.
  function automatic int unsigned clamp_mem_lat(input int unsigned lat);
    if (lat < c_mem_lat_min) begin
      return c_mem_lat_min;
    end
    if (lat > c_mem_lat_max) begin
      return c_mem_lat_max;
    end
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | addr_fetch_unit : walks an external address counter up to a limit,     |
// | reads one sample per address and hands each out on a valid/ready port. |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module addr_fetch_unit
  import ds_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_ADDR_W = 16,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           limit,
  input  logic [31:0]           abus,
  output logic                  cnt_rst,
  output logic                  inc_en,
  output logic                  mem_rd,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sample_cnt
);

  localparam int unsigned c_lat      = clamp_mem_lat(MEM_LAT);
  localparam lat_cnt_t    c_lat_last = lat_cnt_t'(c_lat);

  state_t                state_q,      state_d;
  lat_cnt_t              lat_cnt_q,    lat_cnt_d;
  logic                  cnt_rst_q,    cnt_rst_d;
  logic                  inc_en_q,     inc_en_d;
  logic                  mem_rd_q,     mem_rd_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]     out_data_q,   out_data_d;
  logic                  out_valid_q,  out_valid_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic [31:0]           sample_cnt_q, sample_cnt_d;

  logic w_handshake;
  logic w_run_end;

  assign w_handshake = out_valid_q && out_ready;
  assign w_run_end   = (abus >= limit);

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    cnt_rst_d    = 1'b0;
    inc_en_d     = 1'b0;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    sample_cnt_d = sample_cnt_q;

    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d      = c_st_clr;
          cnt_rst_d    = 1'b1;
          sample_cnt_d = 32'd0;
        end
      end
      c_st_clr: begin
        state_d = c_st_issue;
      end
      c_st_issue: begin
        if (w_run_end) begin
          state_d = c_st_done;
          done_d  = 1'b1;
        end else begin
          state_d    = c_st_wait;
          mem_rd_d   = 1'b1;
          inc_en_d   = 1'b1;
          mem_addr_d = abus[MEM_ADDR_W-1:0];
          lat_cnt_d  = '0;
        end
      end
      c_st_wait: begin
        // The read strobe cycle counts as the first of c_lat+1 wait cycles.
        if (lat_cnt_q == c_lat_last) begin
          state_d     = c_st_hold;
          out_data_d  = mem_rdata;
          out_valid_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      c_st_hold: begin
        if (w_handshake) begin
          state_d      = c_st_issue;
          sample_cnt_d = sample_cnt_q + 32'd1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // A transfer completing on the abort edge still counts; a read in flight is dropped.
    if (abort && (state_q != c_st_idle)) begin
      state_d     = c_st_idle;
      cnt_rst_d   = 1'b0;
      inc_en_d    = 1'b0;
      mem_rd_d    = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      out_data_d  = out_data_q;
    end

    busy_d = (state_d != c_st_idle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_st_idle;
      lat_cnt_q    <= '0;
      cnt_rst_q    <= 1'b0;
      inc_en_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sample_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      cnt_rst_q    <= cnt_rst_d;
      inc_en_q     <= inc_en_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign cnt_rst    = cnt_rst_q;
  assign inc_en     = inc_en_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;

endmodule
`default_nettype wire
